// File: rtl/sd_fifo_word_packer.sv
// sd_fifo_word_packer: packs prefetch-FIFO bytes into 32-bit words with transfer length, sector and last-word tracking
module sd_fifo_word_packer #(
  parameter int CNT_WIDTH    = 16,
  parameter int SECTOR_WORDS = 128,
  parameter bit BIG_ENDIAN   = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [CNT_WIDTH-1:0] xfer_words,
  input  logic                 abort,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_WIDTH-1:0] words_left,
  output logic                 fifo_rd_en,
  input  logic                 fifo_rd_vld,
  input  logic [7:0]           fifo_rd_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [31:0]          m_data,
  output logic                 m_last,
  output logic                 m_sector_end
);
  localparam int SW = SECTOR_WORDS > 1 ? $clog2(SECTOR_WORDS) : 1;
  localparam logic [SW-1:0] SEC_MAX = SW'(SECTOR_WORDS - 1);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state, state_nxt;
  logic [1:0]           byte_idx;
  logic [23:0]          acc;
  logic [CNT_WIDTH-1:0] issue_cnt;
  logic [SW-1:0]        sec_cnt;
  logic                 take, load, accept, last_load, go;
  logic [31:0]          word;
  assign busy = state != IDLE;
  always_comb begin
    fifo_rd_en = state == RUN && !abort && (byte_idx != 2'd3 || !m_valid || m_ready);
    take       = fifo_rd_en && fifo_rd_vld;
    load       = take && byte_idx == 2'd3;
    accept     = m_valid && m_ready;
    last_load  = load && issue_cnt == CNT_WIDTH'(1);
    go         = state == IDLE && start;
    // acc holds {b2,b1,b0}: bytes shift in from the top
    word       = BIG_ENDIAN ? {acc[7:0], acc[15:8], acc[23:16], fifo_rd_data} : {fifo_rd_data, acc};
    state_nxt  = abort                               ? IDLE  :
                 (go && xfer_words != '0)            ? RUN   :
                 (state == RUN && last_load)         ? DRAIN :
                 (state == DRAIN && accept)          ? IDLE  : state;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done         <= 1'b0;
      words_left   <= '0;
      issue_cnt    <= '0;
      sec_cnt      <= '0;
      byte_idx     <= '0;
      acc          <= '0;
      m_valid      <= 1'b0;
      m_data       <= '0;
      m_last       <= 1'b0;
      m_sector_end <= 1'b0;
    end else begin
      done <= !abort && ((go && xfer_words == '0) || (state == DRAIN && accept));
      if (abort) begin
        byte_idx   <= '0;
        acc        <= '0;
        m_valid    <= 1'b0;
        words_left <= '0;
        issue_cnt  <= '0;
      end else begin
        if (go) begin
          words_left <= xfer_words;
          issue_cnt  <= xfer_words;
          sec_cnt    <= '0;
          byte_idx   <= '0;
        end
        if (take) begin
          byte_idx <= byte_idx + 2'd1;
          acc      <= {fifo_rd_data, acc[23:8]};
        end
        if (load) begin
          m_data       <= word;
          m_last       <= issue_cnt == CNT_WIDTH'(1);
          m_sector_end <= sec_cnt == SEC_MAX;
          issue_cnt    <= issue_cnt - CNT_WIDTH'(1);
          sec_cnt      <= sec_cnt == SEC_MAX ? '0 : sec_cnt + SW'(1);
        end
        m_valid <= load || (m_valid && !m_ready);
        if (accept) words_left <= words_left - CNT_WIDTH'(1);
      end
    end
  end
endmodule
